// File: rtl/memory_axil_master.sv
// Load/store front end that turns one request at a time into AXI4-Lite transactions.
// Optional misalignment trap: define MEMORY_AXIL_MISALIGN_TRAP_EN.
module memory_axil_master #(
  parameter  int ADDR_WIDTH   = 16,
  localparam int XLEN         = 32,
  localparam int LS_SEL_WIDTH = 3
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic [LS_SEL_WIDTH:0]   i_Load_Store_Type,
  input  logic [XLEN-1:0]         i_Addr,
  input  logic [XLEN-1:0]         i_Data,
  output logic [XLEN-1:0]         o_Data,
  output logic                    o_Ready,
  output logic                    o_Data_Valid,
  output logic                    o_Write_Done,
  output logic                    o_Error,
  output logic [ADDR_WIDTH-1:0]   o_axil_araddr,
  output logic                    o_axil_arvalid,
  input  logic                    i_axil_arready,
  input  logic [31:0]             i_axil_rdata,
  input  logic [1:0]              i_axil_rresp,
  input  logic                    i_axil_rvalid,
  output logic                    o_axil_rready,
  output logic [ADDR_WIDTH-1:0]   o_axil_awaddr,
  output logic                    o_axil_awvalid,
  input  logic                    i_axil_awready,
  output logic [31:0]             o_axil_wdata,
  output logic [3:0]              o_axil_wstrb,
  output logic                    o_axil_wvalid,
  input  logic                    i_axil_wready,
  input  logic [1:0]              i_axil_bresp,
  input  logic                    i_axil_bvalid,
  output logic                    o_axil_bready
);

  // memory.vh encodings: bit 3 = store, bit 2 = unsigned load, bits [1:0] = size
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LB  = 4'b0000;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LH  = 4'b0001;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LW  = 4'b0010;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LBU = 4'b0100;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_LHU = 4'b0101;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SB  = 4'b1000;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SH  = 4'b1001;
  localparam logic [LS_SEL_WIDTH:0] LS_TYPE_SW  = 4'b1010;

  typedef enum logic [2:0] {IDLE, READ_ADDR, READ_DATA, WRITE_REQ, WRITE_RESP, DONE} state_t;

  state_t                state, state_n;
  logic [LS_SEL_WIDTH:0] type_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [XLEN-1:0]       data_q;
  logic                  aw_done, w_done, err_q;
  logic                  is_load, is_store, accept, trap_in, aw_hs, w_hs;
  logic [1:0]            off;
  logic [XLEN-1:0]       shifted, load_ext;
  logic                  unused_addr;

  assign unused_addr = ^(i_Addr >> ADDR_WIDTH);

  assign is_load  = (i_Load_Store_Type == LS_TYPE_LB)  || (i_Load_Store_Type == LS_TYPE_LH) ||
                    (i_Load_Store_Type == LS_TYPE_LW)  || (i_Load_Store_Type == LS_TYPE_LBU) ||
                    (i_Load_Store_Type == LS_TYPE_LHU);
  assign is_store = (i_Load_Store_Type == LS_TYPE_SB)  || (i_Load_Store_Type == LS_TYPE_SH) ||
                    (i_Load_Store_Type == LS_TYPE_SW);
  assign accept   = (state == IDLE) && (is_load || is_store);

`ifdef MEMORY_AXIL_MISALIGN_TRAP_EN
  assign trap_in = ((i_Load_Store_Type[1:0] == 2'b01) && i_Addr[0]) ||
                   ((i_Load_Store_Type[1:0] == 2'b10) && (i_Addr[1:0] != 2'b00));
`else
  assign trap_in = 1'b0;
`endif

  assign aw_hs = o_axil_awvalid && i_axil_awready;
  assign w_hs  = o_axil_wvalid && i_axil_wready;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (accept) state_n = trap_in ? DONE : (is_load ? READ_ADDR : WRITE_REQ);
      READ_ADDR:  if (i_axil_arready) state_n = READ_DATA;
      READ_DATA:  if (i_axil_rvalid) state_n = DONE;
      WRITE_REQ:  if ((aw_done || aw_hs) && (w_done || w_hs)) state_n = WRITE_RESP;
      WRITE_RESP: if (i_axil_bvalid) state_n = DONE;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Misaligned accesses that reach the bus are forced onto their natural boundary.
  always_comb begin
    off = addr_q[1:0];
    case (type_q[1:0])
      2'b01:   off = {addr_q[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = addr_q[1:0];
    endcase
  end

  always_comb begin
    shifted  = i_axil_rdata >> {off, 3'b000};
    load_ext = shifted;
    case (type_q[1:0])
      2'b00:   load_ext = {{24{~type_q[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~type_q[2] & shifted[15]}}, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    o_axil_wdata = data_q;
    o_axil_wstrb = 4'b1111;
    case (type_q[1:0])
      2'b00: begin
        o_axil_wdata = {4{data_q[7:0]}};
        o_axil_wstrb = 4'b0001 << off;
      end
      2'b01: begin
        o_axil_wdata = {2{data_q[15:0]}};
        o_axil_wstrb = 4'b0011 << off;
      end
      default: begin
        o_axil_wdata = data_q;
        o_axil_wstrb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      type_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_q   <= 1'b0;
      o_Data  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          type_q  <= i_Load_Store_Type;
          addr_q  <= i_Addr[ADDR_WIDTH-1:0];
          data_q  <= i_Data;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          err_q   <= trap_in;
          if (trap_in && is_load) o_Data <= '0;
        end
        READ_DATA: if (i_axil_rvalid) begin
          o_Data <= load_ext;
          err_q  <= (i_axil_rresp != 2'b00);
        end
        WRITE_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        WRITE_RESP: if (i_axil_bvalid) err_q <= (i_axil_bresp != 2'b00);
        default: ;
      endcase
    end
  end

  assign o_Ready        = (state == IDLE);
  assign o_Data_Valid   = (state == DONE) && !type_q[3];
  assign o_Write_Done   = (state == DONE) && type_q[3];
  assign o_Error        = (state == DONE) && err_q;
  assign o_axil_araddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_axil_awaddr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign o_axil_arvalid = (state == READ_ADDR);
  assign o_axil_rready  = (state == READ_DATA);
  assign o_axil_awvalid = (state == WRITE_REQ) && !aw_done;
  assign o_axil_wvalid  = (state == WRITE_REQ) && !w_done;
  assign o_axil_bready  = (state == WRITE_RESP);

endmodule
